// File: rtl/vending_pkg.sv
// vending_pkg: shared states, defaults and width helper for the vending controller
package vending_pkg;
  typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_t;
  localparam logic [31:0] DEF_COIN_VALS = {16'd500, 16'd100};
  localparam logic [63:0] DEF_PRICES = {16'd500, 16'd400, 16'd300, 16'd300};
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/vending_if.sv
// vending_if: front panel and actuator signals of the vending controller
interface vending_if #(parameter int VAL_W = 16, parameter int N_COIN = 2, parameter int N_PROD = 4);
  logic [N_COIN-1:0] coin;
  logic [N_PROD-1:0] prod_btn, prod_empty;
  logic return_btn, vend_done, ret_ack;
  logic [VAL_W-1:0] credit;
  logic seg_en, vend_req, change_req, coin_reject, low_credit;
  logic [vending_pkg::idx_w(N_PROD)-1:0] vend_id;
  modport master (output coin, prod_btn, prod_empty, return_btn, vend_done, ret_ack,
                  input credit, seg_en, vend_req, vend_id, change_req, coin_reject, low_credit);
  modport slave (input coin, prod_btn, prod_empty, return_btn, vend_done, ret_ack,
                 output credit, seg_en, vend_req, vend_id, change_req, coin_reject, low_credit);
endinterface

// File: rtl/vending_edge_rise.sv
// edge_rise: W-bit rising-edge detector against a registered copy of the input
module edge_rise #(parameter int W = 1) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] rise
);
  logic [W-1:0] q;
  always_ff @(posedge clk) q <= reset ? '0 : d;
  assign rise = d & ~q;
endmodule

// File: rtl/vending_controller.sv
// vending_controller: multi-product, multi-coin vending FSM with credit, dispense and change handshakes
module vending_controller import vending_pkg::*; #(
  parameter int VAL_W = 16,
  parameter int N_COIN = 2,
  parameter logic [N_COIN*VAL_W-1:0] COIN_VALS = DEF_COIN_VALS,
  parameter int N_PROD = 4,
  parameter logic [N_PROD*VAL_W-1:0] PRICES = DEF_PRICES,
  parameter int MAX_CREDIT = 2000,
  parameter int RET_UNIT = 100,
  parameter int TIMEOUT_CYC = 30_000_000,
  parameter bit AUTO_CHANGE = 1'b0
) (
  input logic clk,
  input logic reset,
  vending_if.slave bus
);
  localparam int IW = idx_w(N_PROD);
  localparam logic [VAL_W-1:0] RU = VAL_W'(RET_UNIT);
  localparam logic [VAL_W:0] MAXC = (VAL_W+1)'(MAX_CREDIT);
  localparam logic [31:0] TLIM = 32'(TIMEOUT_CYC - 1);
  state_t state, next;
  logic [VAL_W-1:0] credit, coin_val, sel_price, vend_price, rem, pay;
  logic [VAL_W:0] coin_sum;
  logic [IW-1:0] sel, vend_id;
  logic [N_COIN-1:0] coin_rise;
  logic [N_PROD-1:0] btn_rise;
  logic [31:0] tcnt;
  logic coin_any, coin_multi, coin_ok, sel_ok, btn_any, activity, timeout, coin_reject, low_credit;
  edge_rise #(.W(N_COIN)) u_coin (.clk(clk), .reset(reset), .d(bus.coin), .rise(coin_rise));
  edge_rise #(.W(N_PROD)) u_btn (.clk(clk), .reset(reset), .d(bus.prod_btn), .rise(btn_rise));
  // descending loops leave the lowest set index selected
  always_comb begin
    coin_val = '0;
    for (int i = N_COIN - 1; i >= 0; i--) if (coin_rise[i]) coin_val = COIN_VALS[i*VAL_W +: VAL_W];
    sel = '0;
    for (int i = N_PROD - 1; i >= 0; i--) if (bus.prod_btn[i]) sel = IW'(i);
  end
  assign coin_any = |coin_rise;
  assign coin_multi = |(coin_rise & (coin_rise - N_COIN'(1)));
  assign coin_sum = {1'b0, credit} + {1'b0, coin_val};
  assign coin_ok = coin_any && (state == IDLE || state == CREDIT) && coin_sum <= MAXC;
  assign sel_price = PRICES[int'(sel)*VAL_W +: VAL_W];
  assign vend_price = PRICES[int'(vend_id)*VAL_W +: VAL_W];
  assign rem = credit - vend_price;
  assign pay = credit <= RU ? '0 : credit - RU;
  assign sel_ok = credit >= sel_price && !bus.prod_empty[sel];
  assign btn_any = |btn_rise;
  assign activity = coin_any || |bus.prod_btn || bus.return_btn;
  assign timeout = TIMEOUT_CYC != 0 && state == CREDIT && !activity && tcnt == TLIM;
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = coin_ok ? CREDIT : IDLE;
      CREDIT:  next = bus.return_btn || timeout ? CHANGE : btn_any && sel_ok ? VEND : CREDIT;
      VEND:    next = !bus.vend_done ? VEND : rem == '0 ? IDLE : AUTO_CHANGE ? CHANGE : CREDIT;
      CHANGE:  next = credit == '0 || (bus.ret_ack && credit <= RU) ? IDLE : CHANGE;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      credit <= '0;
      tcnt <= '0;
      coin_reject <= 1'b0;
      low_credit <= 1'b0;
      vend_id <= '0;
    end else begin
      state <= next;
      credit <= coin_ok ? coin_sum[VAL_W-1:0] : state == VEND && bus.vend_done ? rem :
                state == CHANGE && bus.ret_ack ? pay : credit;
      tcnt <= state == CREDIT && !activity && !timeout ? tcnt + 32'd1 : '0;
      coin_reject <= coin_any && (coin_multi || !coin_ok);
      low_credit <= state == CREDIT && !bus.return_btn && btn_any && !sel_ok;
      if (state == CREDIT && next == VEND) vend_id <= sel;
    end
  end
  always_comb begin
    bus.seg_en = state != IDLE;
    bus.vend_req = state == VEND;
    bus.change_req = state == CHANGE;
    bus.credit = credit;
    bus.vend_id = vend_id;
    bus.coin_reject = coin_reject;
    bus.low_credit = low_credit;
  end
endmodule
